player_bullet_controller: RTL

Downstream consumer of the player sprite position (sprite_x/sprite_y, top-left of the 32x32 player sprite). Manages a fixed pool of player bullets:
- spawns a bullet above the sprite centre while fire is requested and cooldown allows;
- moves active bullets upward on a divided tick;
- retires bullets at the screen top or on a collision-clear request.

Its outputs feed the bullet renderer and collision logic.

---
 rtl/player_bullet_controller_pkg.sv | 38 +++
 rtl/player_bullet_controller_bullet_slot_alloc.sv | 37 +++
 rtl/player_bullet_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/player_bullet_controller_pkg.sv
// ---------------------------------------------------------------------------
// player_bullet_controller_pkg
//
// Purpose:
//   Screen and sprite geometry shared by the sprite controller, the bullet
//   controllers and the renderer, plus the coordinate type and a small
//   helper for centring one object horizontally on another.
//
// Contents:
//   COORD_W              - width of every screen coordinate (10 bits)
//   SCREEN_W / SCREEN_H  - visible screen size in pixels
//   SPRITE_W / SPRITE_H  - player sprite size in pixels
//   BULLET_*_DEFAULT     - default bullet geometry and speed
//   coord_t              - unsigned screen coordinate
//   centre_offset()      - x offset that centres an inner object on an outer
// ---------------------------------------------------------------------------
package player_bullet_controller_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;

  localparam int BULLET_W_DEFAULT    = 4;
  localparam int BULLET_H_DEFAULT    = 8;
  localparam int BULLET_STEP_DEFAULT = 2;

  typedef logic [COORD_W-1:0] coord_t;

  // Offset from the outer object's left edge to the inner object's left edge
  // so that both share the same horizontal centre. Truncated to the
  // coordinate width so it can be added with natural 10-bit wrap.
  function automatic coord_t centre_offset(input int outer_w, input int inner_w);
    return coord_t'(outer_w / 2 - inner_w / 2);
  endfunction

endpackage

// File: rtl/player_bullet_controller_bullet_slot_alloc.sv
// ---------------------------------------------------------------------------
// bullet_slot_alloc
//
// Purpose:
//   Combinational priority encoder that finds the lowest-index free slot of
//   a bullet pool. Shared between the player and enemy bullet pools.
//
// Ports:
//   active      in   NUM_SLOTS  slot i is occupied when active[i]=1
//   free_valid  out  1          at least one slot is free
//   free_idx    out  IDX_W      index of the lowest free slot (0 if none)
// ---------------------------------------------------------------------------
module bullet_slot_alloc
  import player_bullet_controller_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [NUM_SLOTS-1:0] active,
  output logic                 free_valid,
  output logic [IDX_W-1:0]     free_idx
);

  // Scan from the top slot downwards so that the last hit, which wins, is
  // the lowest-index free slot.
  always_comb begin
    free_valid = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_valid = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/player_bullet_controller.sv
// ---------------------------------------------------------------------------
// player_bullet_controller
//
// Purpose:
//   Owns a fixed pool of player bullets. While fire is held and the cooldown
//   has expired, a bullet is spawned centred just above the player sprite.
//   Active bullets climb the screen on a divided movement tick and are
//   retired when they reach the top or when collision logic clears them.
//
// Ports:
//   clk25          in   1              pixel clock, rising edge
//   reset          in   1              synchronous, active-high
//   btn_fire       in   1              fire request (held = auto-fire)
//   sprite_x       in   10             player sprite top-left x
//   sprite_y       in   10             player sprite top-left y
//   hit_clear      in   NUM_BULLETS    per-slot kill request
//   bullet_active  out  NUM_BULLETS    slot i in flight
//   bullet_x       out  NUM_BULLETS*10 slot i x at [10i+9:10i]
//   bullet_y       out  NUM_BULLETS*10 slot i y at [10i+9:10i]
//   fire_event     out  1              one-cycle pulse the cycle after a spawn
// ---------------------------------------------------------------------------
module player_bullet_controller
  import player_bullet_controller_pkg::*;
#(
  parameter int NUM_BULLETS    = 4,
  parameter int BULLET_W       = 4,
  parameter int BULLET_H       = 8,
  parameter int SPRITE_W       = 32,
  parameter int MOVE_DIV_BIT   = 16,
  parameter int BULLET_STEP    = 2,
  parameter int COOLDOWN_TICKS = 20
) (
  input  logic                         clk25,
  input  logic                         reset,
  input  logic                         btn_fire,
  input  logic [COORD_W-1:0]           sprite_x,
  input  logic [COORD_W-1:0]           sprite_y,
  input  logic [NUM_BULLETS-1:0]       hit_clear,
  output logic [NUM_BULLETS-1:0]       bullet_active,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
  output logic                         fire_event
);

  localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CD_W  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  localparam coord_t SPAWN_X_OFF = centre_offset(SPRITE_W, BULLET_W);
  localparam coord_t SPAWN_Y_OFF = coord_t'(BULLET_H);
  localparam coord_t STEP        = coord_t'(BULLET_STEP);

  localparam logic [MOVE_DIV_BIT:0] TICK_LAST = {1'b0, {MOVE_DIV_BIT{1'b1}}};
  localparam logic [CD_W-1:0]       CD_LOAD   = CD_W'(COOLDOWN_TICKS);

  logic [MOVE_DIV_BIT:0]       tick_cnt;
  logic                        tick;
  logic [CD_W-1:0]             cooldown;
  logic [NUM_BULLETS-1:0]      active_q;
  coord_t [NUM_BULLETS-1:0]    x_q;
  coord_t [NUM_BULLETS-1:0]    y_q;
  logic                        free_valid;
  logic [IDX_W-1:0]            free_idx;
  logic                        spawn;

  // Allocation looks only at registered occupancy, so a slot retired this
  // cycle cannot be handed out again until the following cycle.
  bullet_slot_alloc #(
    .NUM_SLOTS (NUM_BULLETS),
    .IDX_W     (IDX_W)
  ) u_alloc (
    .active     (active_q),
    .free_valid (free_valid),
    .free_idx   (free_idx)
  );

  assign tick  = (tick_cnt == TICK_LAST);

  // A spawn needs the button, an expired cooldown, a free slot and enough
  // room above the sprite for the whole bullet without wrapping y.
  assign spawn = btn_fire && (cooldown == '0) && free_valid && (sprite_y >= SPAWN_Y_OFF);

  // Free-running movement divider: it wraps on the cycle tick is high, so
  // tick lasts exactly one cycle every 2^MOVE_DIV_BIT cycles.
  always_ff @(posedge clk25) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Cooldown is reloaded by every spawn and then counts movement ticks down
  // to zero. A spawn can only happen at zero, so load and decrement never
  // compete for the same cycle in a meaningful way.
  always_ff @(posedge clk25) begin
    if (reset) begin
      cooldown <= '0;
    end else if (spawn) begin
      cooldown <= CD_LOAD;
    end else if (tick && (cooldown != '0)) begin
      cooldown <= cooldown - 1'b1;
    end
  end

  // Per-slot state. Priority is hit_clear, then spawn, then move. A hit
  // only matters on an occupied slot and a spawn only targets a free one,
  // so the spawned slot naturally skips movement on its spawn cycle. A
  // bullet that cannot take a full step without going negative is retired
  // in place, leaving its last coordinates on the outputs.
  always_ff @(posedge clk25) begin
    if (reset) begin
      active_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (hit_clear[i] && active_q[i]) begin
          active_q[i] <= 1'b0;
        end else if (spawn && (free_idx == IDX_W'(i))) begin
          active_q[i] <= 1'b1;
          x_q[i]      <= sprite_x + SPAWN_X_OFF;
          y_q[i]      <= sprite_y - SPAWN_Y_OFF;
        end else if (tick && active_q[i]) begin
          if (y_q[i] < STEP) begin
            active_q[i] <= 1'b0;
          end else begin
            y_q[i] <= y_q[i] - STEP;
          end
        end
      end
    end
  end

  // Registered spawn strobe for sound/score logic downstream.
  always_ff @(posedge clk25) begin
    if (reset) begin
      fire_event <= 1'b0;
    end else begin
      fire_event <= spawn;
    end
  end

  assign bullet_active = active_q;
  assign bullet_x      = x_q;
  assign bullet_y      = y_q;

endmodule
